// File: rtl/switch_debounce_4.sv
// switch_debounce_4: two-flop synchroniser plus per-bit debounce for the four
// slide switches feeding the Gray-to-binary converter (o_sw[n] -> i_swn).
//
// Parameters:
//   DEBOUNCE_CYCLES  number of consecutive mismatching cycles before a bit updates (>= 2)
//   CNT_W            counter width, 2**CNT_W > DEBOUNCE_CYCLES-1
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_sw        raw switch pins, asynchronous to i_clk
//   i_err_clr   synchronous clear of o_gray_err
//   o_sw        debounced switch word
//   o_change    one-cycle pulse on the first cycle a new o_sw is visible
//   o_gray_err  sticky flag: an o_sw update changed more than one bit
// Configuration:
//   GRAY_STEP_CHECK_EN  when defined, enables the multi-bit-step checker;
//                       otherwise o_gray_err is tied to 0 and i_err_clr is unused.

module switch_debounce_4 #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_sw,
    input  logic       i_err_clr,
    output logic [3:0] o_sw,
    output logic       o_change,
    output logic       o_gray_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       sw_q;
    logic [3:0]       sw_d;
    logic             change_q;
    logic             change_d;

    // Synchroniser: plain two-flop chain per bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= i_sw;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: count consecutive mismatches, update on the last one.
    // A match at any point drops the count back to 0, so glitches are discarded.
    always_comb begin
        sw_d = sw_q;
        for (int n = 0; n < 4; n++) begin
            cnt_d[n] = '0;
            if (sync2_q[n] != sw_q[n]) begin
                if (cnt_q[n] == CNT_LAST) begin
                    sw_d[n]  = sync2_q[n];
                    cnt_d[n] = '0;
                end else begin
                    cnt_d[n] = cnt_q[n] + CNT_ONE;
                end
            end
        end
    end

    // One pulse regardless of how many bits move on the same edge.
    always_comb begin
        change_d = (sw_d != sw_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_q     <= 4'b0000;
            change_q <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            sw_q     <= sw_d;
            change_q <= change_d;
            for (int n = 0; n < 4; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign o_sw     = sw_q;
    assign o_change = change_q;

`ifdef GRAY_STEP_CHECK_EN
    logic [3:0] flip;
    logic       multi_step;
    logic       gray_err_q;
    logic       gray_err_d;

    // x & (x-1) is non-zero exactly when more than one bit of x is set.
    always_comb begin
        flip       = sw_d ^ sw_q;
        multi_step = |(flip & (flip - 4'd1));
    end

    // A new violation wins over a clear on the same edge.
    always_comb begin
        gray_err_d = gray_err_q;
        if (multi_step) begin
            gray_err_d = 1'b1;
        end else if (i_err_clr) begin
            gray_err_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gray_err_q <= 1'b0;
        end else begin
            gray_err_q <= gray_err_d;
        end
    end

    assign o_gray_err = gray_err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = i_err_clr;
    assign o_gray_err     = 1'b0;
`endif

endmodule

// File: doc/switch_debounce_4.md
# switch_debounce_4

Input conditioning stage for the four slide switches that drive the Gray-to-binary/hex display path. It synchronises each raw switch to `i_clk` and debounces it with a per-bit counter. It presents the clean 4-bit Gray code word that the converter consumes as `i_sw0..i_sw3`. An optional checker flags debounced updates that violate the single-bit Gray step.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive cycles a synchronised bit must differ from its debounced value before the debounced value updates. Legal range is ≥ 2. The default gives 5 ms at 50 MHz.
- `CNT_W`, default 18: counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES − 1.

Ports:
- `i_clk`  in  1  single clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_sw`  in  4  raw switch pins, asynchronous to `i_clk`; bit n feeds `i_swn` downstream.
- `i_err_clr`  in  1  synchronous clear of `o_gray_err`.
- `o_sw`  out  4  debounced switch word; bit n drives converter input `i_swn`.
- `o_change`  out  1  one-cycle pulse marking an `o_sw` update.
- `o_gray_err`  out  1  sticky multi-bit-step flag (see Configuration).

## Operation
- Synchroniser: two flops per bit, `sync1` then `sync2`. Both reset to 0.
- Per-bit debounce, with `cnt[n]` of width CNT_W:
  - `sync2[n] == o_sw[n]`: `cnt[n]` is set to 0.
  - `sync2[n] != o_sw[n]` and `cnt[n] < DEBOUNCE_CYCLES−1`: `cnt[n]` increments.
  - `sync2[n] != o_sw[n]` and `cnt[n] == DEBOUNCE_CYCLES−1`: `o_sw[n]` takes `sync2[n]` and `cnt[n]` is set to 0.
  - Any mismatch run shorter than DEBOUNCE_CYCLES is discarded with no output change. A bounce back to the old value restarts the count from 0.
- The four bits are fully independent. Bits may update on the same edge.
- `o_change` is registered. It is 1 for exactly the first cycle in which the new `o_sw` value is visible, and 0 otherwise. Any number of bits updating on one edge produce a single pulse.
- Counters saturate-free by construction: `cnt[n]` never exceeds DEBOUNCE_CYCLES−1, so no wrap-around occurs.
- Reset values: `o_sw`=4'b0000, `o_change`=0, `o_gray_err`=0, all counters 0, all sync flops 0.
- A switch held high through reset appears on `o_sw` DEBOUNCE_CYCLES+1 edges after the first post-reset sampling edge. It produces an `o_change` pulse when it does.
- Reset asserted mid-count clears the count immediately. The in-progress change is lost and the count restarts after release.

## Timing
- Let edge k be the edge at which `sync1` first captures a new stable `i_sw[n]` level.
- `sync2` shows the new level after edge k+1.
- `o_sw[n]` and `o_change` update at edge k+1+DEBOUNCE_CYCLES. Latency is therefore DEBOUNCE_CYCLES+1 cycles from the capturing edge.
- There is no combinational path from any input to any output.
- `i_err_clr` and an error-setting update on the same edge: set wins, so `o_gray_err`=1.

## Configuration
- Macro `GRAY_STEP_CHECK_EN`.
- Defined:
  - On every edge where `o_sw` updates with more than one bit changing, `o_gray_err` is set to 1.
  - `o_gray_err` holds 1 until an edge with `i_err_clr`=1 and no new violation.
- Undefined:
  - `o_gray_err` is tied to 0.
  - `i_err_clr` is ignored.
  - Ports are unchanged and no checker logic is present.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, CNT_W=3.
- Reset behaviour: assert `i_rst_n`=0 mid-simulation with `i_sw`=4'hF held. Required: `o_sw`=0, `o_change`=0, `o_gray_err`=0 immediately and asynchronously. `o_sw`=4'hF with one `o_change` pulse 5 edges after release.
- Clean step: `i_sw` 0000→0001, captured at edge k. Required: `o_sw`=0001 after edge k+5, and `o_change` high for exactly that one cycle.
- Bounce rejection: `i_sw[2]` toggles high for 3 cycles, low for 1, then stays high. Required: no change during the 3-cycle glitch. `o_sw[2]`=1 exactly 5 edges after the final rising capture, with a single `o_change` pulse.
- Simultaneous bits: `i_sw` 0000→0011 in one cycle. Required: `o_sw`=0011 after edge k+5 with one `o_change` pulse. With `GRAY_STEP_CHECK_EN`, `o_gray_err`=1 and sticky.
- Error clear: with the flag set, pulse `i_err_clr` for 1 cycle while no update occurs. Required: `o_gray_err`=0 next edge. Then repeat `i_err_clr` on the same edge as a 0011→1100 update. Required: `o_gray_err` stays 1.
- Macro off: repeat the simultaneous-bits scenario without the macro. Required: `o_gray_err` remains 0 throughout.
